// File: rtl/sseg_scan_bcd.sv
// Time-multiplexed BCD-to-seven-segment driver for N common-anode digits.
// Latches a packed BCD word on load and scans it with a dark slot between digits.
module sseg_scan_bcd #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  wrap;

  logic [3:0]            code;
  logic                  dp_cur;
  logic                  supp_cur;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            sseg_next;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b100_0000;
      4'd1:    seg_pat = 7'b111_1001;
      4'd2:    seg_pat = 7'b010_0100;
      4'd3:    seg_pat = 7'b011_0000;
      4'd4:    seg_pat = 7'b001_1001;
      4'd5:    seg_pat = 7'b001_0010;
      4'd6:    seg_pat = 7'b000_0010;
      4'd7:    seg_pat = 7'b111_1000;
      4'd8:    seg_pat = 7'b000_0000;
      4'd9:    seg_pat = 7'b001_0000;
      default: seg_pat = 7'b111_1111;
    endcase
  endfunction

  assign wrap = (cnt == CNT_LAST);

  // load is a single-cycle strobe with no back-pressure: bcd/dp_in are
  // captured at any edge where load is high; the scan is never disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      dp_q     <= '0;
    end else if (load) begin
      digits_q <= bcd;
      dp_q     <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Walk from the top digit down so zero_run says "this digit and all above are 0".
  always_comb begin
    code     = '0;
    dp_cur   = 1'b0;
    supp_cur = 1'b0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (digits_q[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        code     = digits_q[4*i +: 4];
        dp_cur   = dp_q[i];
        supp_cur = zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    an_next = wrap ? '1 : ~(N_DIGITS'(1) << idx);
    if (code == 4'hF)
      sseg_next = 8'h00;
    else if (code > 4'd9)
      sseg_next = 8'h7F;
    else if (lz_en && supp_cur)
      sseg_next = {~dp_cur, 7'h7F};
    else
      sseg_next = {~dp_cur, seg_pat(code)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule
